mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter sharing one unified instruction/data memory between the pipelined core's fetch port and its load/store port. Each cycle it selects at most one requester and drives the memory for that access. It then counts the fixed read latency and returns the read data and a response strobe to the owner. Data accesses have priority; a starvation counter guarantees forward progress for fetch. It sits between the core and the memory in place of separate instruction and data memories, and its ready signals feed the hazard unit as stall sources.

## Interface
- LATENCY, 1: memory cycles from issue to valid m_rdata (1..8).
- STARVE_MAX, 4: consecutive denied fetch-request cycles before fetch wins (1..15).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low: 0 resets all state immediately; released synchronously by the source.
- i_req  in  1  fetch request; i_addr held stable until i_ready.
- i_addr  in  32  fetch byte address.
- i_ready  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid on i_rdata.
- i_rdata  out  32  fetch read data.
- d_req  in  1  data request; d_addr/d_we/d_wdata held stable until d_ready.
- d_we  in  4  byte write enables; 4'b0000 means read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  data response (read data, or write acknowledge).
- d_rdata  out  32  data read data (undefined for writes).
- m_en  out  1  memory access strobe.
- m_we  out  4  memory byte write enables.
- m_addr  out  32  memory byte address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid LATENCY cycles after m_en.

## Operation
- States: IDLE, WAIT. Registers: state, owner (OWN_I/OWN_D), lat_cnt (3 bits), starve_cnt (4 bits).
- Response cycle: state==WAIT and lat_cnt==0.
- Grant allowed: state==IDLE, or the response cycle.
- Winner: if starve_cnt==STARVE_MAX and i_req, fetch; else if d_req, data; else if i_req, fetch; else none.
- On a grant, in the same cycle (combinational):
  - The winner's ready is 1.
  - m_en=1; m_addr/m_we/m_wdata come from the winner. m_we is 0 for fetch.
- On the next edge after a grant: state=WAIT, owner=winner, lat_cnt=LATENCY-1.
- In WAIT with lat_cnt≠0: lat_cnt decrements and no grant is made.
- Response cycle:
  - The owner's rvalid is 1, with rdata = m_rdata passed through.
  - If no new grant is made in this cycle, next state is IDLE.
- The non-owner's rvalid is 0; i_rdata/d_rdata are driven from m_rdata at all times.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, on every cycle with i_req=1 and i_ready=0.
  - Clears on i_ready.
  - Holds when i_req=0.
- Requesters may drop req only after ready. A req withdrawn before grant is simply not served.

## Timing
- Reset (reset=0): state=IDLE, owner=OWN_I, lat_cnt=0, starve_cnt=0.
- Outputs are forced to 0 during reset regardless of inputs: m_en, m_we, i_ready, d_ready, i_rvalid, d_rvalid.
- Latency: grant at cycle T gives rvalid at cycle T+LATENCY.
- Throughput: one access per LATENCY cycles (every cycle when LATENCY=1, via grant in the response cycle).
- Simultaneous i_req and d_req: data wins unless the starvation condition holds.
- Reset asserted mid-access: the outstanding response is discarded and no rvalid is issued afterwards. The memory access may already have taken effect.
- Width rules:
  - lat_cnt must hold LATENCY-1 (max 7).
  - starve_cnt never exceeds STARVE_MAX.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum logic {IDLE, WAIT} arb_state_e
  - typedef enum logic {OWN_I, OWN_D} arb_owner_e
  - localparam widths for lat_cnt (3) and starve_cnt (4)
- Single module; no sub-module. Winner selection is one always_comb block, and state/counters are one always_ff with asynchronous active-low reset.

## Test plan
- Reset: hold reset=0 with i_req=d_req=1 → all ready/rvalid/m_en stay 0. Release reset → first grant goes to data.
- LATENCY=1, fetch only: i_req=1 at addresses 0x0, 0x4, 0x8 on consecutive cycles → i_ready every cycle, i_rvalid one cycle later with the mem contents.
- LATENCY=3, simultaneous requests: d_req read 0x100 and i_req 0x0 → d_ready at T, d_rvalid at T+3. At T+3, i_ready (starve_cnt=3 <4 and d_req low) and i_rvalid at T+6.
- Starvation, STARVE_MAX=4, LATENCY=1: d_req and i_req held high continuously → i_ready on the 5th cycle, then data resumes. starve_cnt cleared.
- Write: d_we=4'b0011, d_wdata=0xDEADBEEF at 0x200 → m_we=4'b0011 during d_ready, d_rvalid after LATENCY. A subsequent read of 0x200 returns the low half 0xBEEF merged with the old upper bytes.
- Reset mid-WAIT (LATENCY=4, reset low at T+2) → no d_rvalid at T+4; state IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and counter widths for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE, WAIT} arb_state_e;
  typedef enum logic {OWN_I, OWN_D} arb_owner_e;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data-priority grant between fetch and load/store,
// fixed-latency response return, and a starvation counter that forces fetch through.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(LATENCY - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e            state;
  arb_owner_e            owner;
  logic [LAT_W-1:0]      lat_cnt;
  logic [STARVE_W-1:0]   starve_cnt;

  logic resp;
  logic grant_ok;
  logic starved;
  logic pick_i;
  logic pick_d;

  // reset is active-low; gating with it keeps every strobe at 0 while held in reset
  always_comb begin
    resp     = 1'b0;
    grant_ok = 1'b0;
    starved  = 1'b0;
    pick_i   = 1'b0;
    pick_d   = 1'b0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    m_en     = 1'b0;
    m_we     = 4'b0000;
    m_addr   = i_addr;
    m_wdata  = '0;

    resp     = (state == WAIT) && (lat_cnt == '0);
    grant_ok = reset && ((state == IDLE) || resp);
    starved  = (starve_cnt == STARVE_LIM);
    pick_i   = grant_ok && i_req && (starved || !d_req);
    pick_d   = grant_ok && d_req && !(starved && i_req);

    i_ready  = pick_i;
    d_ready  = pick_d;
    m_en     = pick_i || pick_d;
    if (pick_d) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end

    i_rvalid = reset && resp && (owner == OWN_I);
    d_rvalid = reset && resp && (owner == OWN_D);
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // A grant in the response cycle restarts WAIT directly, giving back-to-back accesses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_I;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (m_en) begin
        state   <= WAIT;
        owner   <= pick_d ? OWN_D : OWN_I;
        lat_cnt <= LAT_INIT;
      end else if (state == WAIT) begin
        if (lat_cnt != '0)
          lat_cnt <= lat_cnt - 1'b1;
        else
          state <= IDLE;
      end

      if (i_ready)
        starve_cnt <= '0;
      else if (i_req && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (LATENCY 1, 3, 4) each with a
// small latency-pipelined memory whose word at byte address a holds 0xA0000000+a.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  i_req, d_req;
  logic [2:0]  i_ready, i_rvalid, d_ready, d_rvalid, m_en;
  logic [31:0] i_addr [3];
  logic [31:0] d_addr [3];
  logic [31:0] d_wdata [3];
  logic [3:0]  d_we [3];
  logic [31:0] i_rdata [3];
  logic [31:0] d_rdata [3];
  logic [3:0]  m_we [3];
  logic [31:0] m_addr [3];
  logic [31:0] m_wdata [3];
  logic [31:0] m_rdata [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_arb
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;

    logic [31:0] mem  [256];
    logic [31:0] pipe [L];

    mem_arbiter #(.LATENCY(L), .STARVE_MAX(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_ready  (i_ready[g]),
      .i_rvalid (i_rvalid[g]),
      .i_rdata  (i_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_ready  (d_ready[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .m_en     (m_en[g]),
      .m_we     (m_we[g]),
      .m_addr   (m_addr[g]),
      .m_wdata  (m_wdata[g]),
      .m_rdata  (m_rdata[g])
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
      for (int s = 0; s < L; s++) pipe[s] = '0;
    end

    // Read data appears L cycles after the strobe; writes merge by byte lane
    always @(posedge clk) begin
      if (m_en[g]) begin
        pipe[0] <= mem[m_addr[g][9:2]];
        for (int b = 0; b < 4; b++)
          if (m_we[g][b]) mem[m_addr[g][9:2]][8*b +: 8] <= m_wdata[g][8*b +: 8];
      end
      for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
    end

    assign m_rdata[g] = pipe[L-1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus on instance k, then settle just after the falling edge
  task automatic applyStimulus(input int k, input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic [3:0] we,
                               input logic [31:0] daddr, input logic [31:0] wdata);
    @(negedge clk);
    i_req[k]   = ireq;
    i_addr[k]  = iaddr;
    d_req[k]   = dreq;
    d_we[k]    = we;
    d_addr[k]  = daddr;
    d_wdata[k] = wdata;
    #1;
  endtask

  task automatic idleAll();
    for (int k = 0; k < 3; k++) begin
      i_req[k]   = 1'b0;
      d_req[k]   = 1'b0;
      i_addr[k]  = '0;
      d_addr[k]  = '0;
      d_we[k]    = '0;
      d_wdata[k] = '0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    idleAll();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b0;
    idleAll();

    // Reset held with both requests asserted on every instance
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      i_req[k]  = 1'b1;
      d_req[k]  = 1'b1;
      d_addr[k] = 32'h100;
    end
    @(negedge clk);
    #1;
    checkOutput("rst_i_ready",  32'(i_ready),  32'd0);
    checkOutput("rst_d_ready",  32'(d_ready),  32'd0);
    checkOutput("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("rst_m_en",     32'(m_en),     32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rel_d_ready", 32'(d_ready), 32'h7);
    checkOutput("rel_i_ready", 32'(i_ready), 32'h0);
    checkOutput("rel_m_addr",  m_addr[0],    32'h100);

    // LATENCY=1, fetch-only stream 0x0, 0x4, 0x8
    doReset();
    applyStimulus(0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("f_ready0",  32'(i_ready[0]), 32'd1);
    checkOutput("f_maddr0",  m_addr[0],       32'h0);
    checkOutput("f_mwe0",    32'(m_we[0]),    32'd0);
    applyStimulus(0, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("f_ready1",  32'(i_ready[0]),  32'd1);
    checkOutput("f_rvalid1", 32'(i_rvalid[0]), 32'd1);
    checkOutput("f_rdata1",  i_rdata[0],       32'hA000_0000);
    applyStimulus(0, 1'b1, 32'h8, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("f_ready2",  32'(i_ready[0]),  32'd1);
    checkOutput("f_rdata2",  i_rdata[0],       32'hA000_0004);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("f_rvalid3", 32'(i_rvalid[0]), 32'd1);
    checkOutput("f_rdata3",  i_rdata[0],       32'hA000_0008);
    checkOutput("f_ready3",  32'(i_ready[0]),  32'd0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("f_rvalid4", 32'(i_rvalid[0]), 32'd0);

    // LATENCY=3, simultaneous requests: data first, fetch at T+3, fetch data at T+6
    doReset();
    applyStimulus(1, 1'b1, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
    checkOutput("l3_d_ready_T", 32'(d_ready[1]), 32'd1);
    checkOutput("l3_i_ready_T", 32'(i_ready[1]), 32'd0);
    applyStimulus(1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("l3_i_ready_T1",  32'(i_ready[1]),  32'd0);
    checkOutput("l3_d_rvalid_T1", 32'(d_rvalid[1]), 32'd0);
    applyStimulus(1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("l3_d_rvalid_T2", 32'(d_rvalid[1]), 32'd0);
    applyStimulus(1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("l3_d_rvalid_T3", 32'(d_rvalid[1]), 32'd1);
    checkOutput("l3_d_rdata_T3",  d_rdata[1],       32'hA000_0100);
    checkOutput("l3_i_ready_T3",  32'(i_ready[1]),  32'd1);
    checkOutput("l3_m_addr_T3",   m_addr[1],        32'h0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("l3_i_rvalid_T4", 32'(i_rvalid[1]), 32'd0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("l3_i_rvalid_T5", 32'(i_rvalid[1]), 32'd0);
    applyStimulus(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("l3_i_rvalid_T6", 32'(i_rvalid[1]), 32'd1);
    checkOutput("l3_i_rdata_T6",  i_rdata[1],       32'hA000_0000);
    checkOutput("l3_d_rvalid_T6", 32'(d_rvalid[1]), 32'd0);

    // Starvation at LATENCY=1: fetch forced through on the 5th cycle, then again 5 later
    doReset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h100, 32'h0);
      checkOutput($sformatf("st_d_ready_c%0d", c), 32'(d_ready[0]), 32'd1);
      checkOutput($sformatf("st_i_ready_c%0d", c), 32'(i_ready[0]), 32'd0);
    end
    applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h100, 32'h0);
    checkOutput("st_i_ready_c4", 32'(i_ready[0]), 32'd1);
    checkOutput("st_d_ready_c4", 32'(d_ready[0]), 32'd0);
    checkOutput("st_m_addr_c4",  m_addr[0],       32'h40);
    applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h100, 32'h0);
    checkOutput("st_d_ready_c5",  32'(d_ready[0]),  32'd1);
    checkOutput("st_i_rvalid_c5", 32'(i_rvalid[0]), 32'd1);
    checkOutput("st_i_rdata_c5",  i_rdata[0],       32'hA000_0040);
    repeat (3) applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h100, 32'h0);
    checkOutput("st_i_ready_c8", 32'(i_ready[0]), 32'd0);
    applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'h100, 32'h0);
    checkOutput("st_i_ready_c9", 32'(i_ready[0]), 32'd1);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Partial write then read-back at LATENCY=1
    doReset();
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
    checkOutput("wr_d_ready", 32'(d_ready[0]), 32'd1);
    checkOutput("wr_m_we",    32'(m_we[0]),    32'b0011);
    checkOutput("wr_m_wdata", m_wdata[0],      32'hDEAD_BEEF);
    checkOutput("wr_m_addr",  m_addr[0],       32'h200);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("wr_d_rvalid", 32'(d_rvalid[0]), 32'd1);
    applyStimulus(0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0);
    checkOutput("rd_d_ready", 32'(d_ready[0]), 32'd1);
    checkOutput("rd_m_we",    32'(m_we[0]),    32'd0);
    applyStimulus(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("rd_d_rvalid", 32'(d_rvalid[0]), 32'd1);
    checkOutput("rd_d_rdata",  d_rdata[0],       32'hA000_BEEF);

    // LATENCY=4: reset at T+2 discards the outstanding read
    doReset();
    applyStimulus(2, 1'b0, 32'h0, 1'b1, 4'h0, 32'h100, 32'h0);
    checkOutput("mr_d_ready_T", 32'(d_ready[2]), 32'd1);
    applyStimulus(2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mr_d_rvalid_T2", 32'(d_rvalid[2]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(2, 1'b0, 32'h0, 1'b1, 4'h0, 32'h104, 32'h0);
    checkOutput("mr_d_rvalid_T4", 32'(d_rvalid[2]), 32'd0);
    checkOutput("mr_d_ready_T4",  32'(d_ready[2]),  32'd1);
    applyStimulus(2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("mr_d_rvalid_T5", 32'(d_rvalid[2]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
